// File: rtl/cla_serial_sub_pkg.sv
// Shared types for the serial CLA subtractor: FSM state encoding.
package cla_serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cla_serial_sub_cla2_slice.sv
// Purely combinational 2-bit carry-lookahead adder slice.
module cla2_slice (
    input  logic [1:0] x,
    input  logic [1:0] y,
    input  logic       cin,
    output logic [1:0] s,
    output logic       cout
);

    logic [1:0] g;
    logic [1:0] p;
    logic       c1;

    always_comb begin
        g    = x & y;
        p    = x ^ y;
        c1   = g[0] | (p[0] & cin);
        s    = {p[1] ^ c1, p[0] ^ cin};
        cout = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    end

endmodule

// File: rtl/cla_serial_sub.sv
// Multi-cycle subtractor: a - b computed as a + ~b + 1, two bits per clock
// through one shared cla2_slice, with valid/ready handshakes on both sides.
module cla_serial_sub
    import cla_serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int unsigned N  = WIDTH / 2;
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    generate
        if ((WIDTH % 2) != 0 || WIDTH < 2) begin : g_width_check
            $error("cla_serial_sub: WIDTH must be even and >= 2");
        end
    endgenerate

    state_t            state, state_n;
    logic [WIDTH-1:0]  a_r, a_n;
    logic [WIDTH-1:0]  b_r, b_n;
    logic [IW-1:0]     idx, idx_n;
    logic              carry, carry_n;
    logic [WIDTH-1:0]  diff_n;
    logic              borrow_n, overflow_n;
    logic              in_ready_n, out_valid_n;

    logic [IW:0]       sh;
    logic [1:0]        sl_x, sl_y, sl_s;
    logic              sl_cout;
    logic [WIDTH-1:0]  mask, ins;

    // Select the current 2-bit slice of the operands; subtrahend is inverted.
    always_comb begin
        sh   = {idx, 1'b0};
        sl_x = 2'(a_r >> sh);
        sl_y = ~(2'(b_r >> sh));
        mask = WIDTH'(2'b11) << sh;
        ins  = WIDTH'(sl_s) << sh;
    end

    cla2_slice u_slice (
        .x    (sl_x),
        .y    (sl_y),
        .cin  (carry),
        .s    (sl_s),
        .cout (sl_cout)
    );

    always_comb begin
        state_n     = state;
        a_n         = a_r;
        b_n         = b_r;
        idx_n       = idx;
        carry_n     = carry;
        diff_n      = diff;
        borrow_n    = borrow_out;
        overflow_n  = overflow;
        in_ready_n  = in_ready;
        out_valid_n = out_valid;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    a_n        = a;
                    b_n        = b;
                    idx_n      = '0;
                    carry_n    = 1'b1;
                    in_ready_n = 1'b0;
                    state_n    = RUN;
                end
            end
            RUN: begin
                diff_n  = (diff & ~mask) | ins;
                carry_n = sl_cout;
                idx_n   = idx + IW'(1);
                if (idx == IW'(N - 1)) begin
                    borrow_n    = ~sl_cout;
                    overflow_n  = (a_r[WIDTH-1] != b_r[WIDTH-1]) && (sl_s[1] != a_r[WIDTH-1]);
                    out_valid_n = 1'b1;
                    state_n     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_n = 1'b0;
                    in_ready_n  = 1'b1;
                    state_n     = IDLE;
                end
            end
            default: begin
                state_n     = IDLE;
                in_ready_n  = 1'b1;
                out_valid_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            a_r        <= '0;
            b_r        <= '0;
            idx        <= '0;
            carry      <= 1'b1;
            diff       <= '0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
        end else begin
            state      <= state_n;
            a_r        <= a_n;
            b_r        <= b_n;
            idx        <= idx_n;
            carry      <= carry_n;
            diff       <= diff_n;
            borrow_out <= borrow_n;
            overflow   <= overflow_n;
            in_ready   <= in_ready_n;
            out_valid  <= out_valid_n;
        end
    end

endmodule

// File: tb/tb_cla_serial_sub.sv
// Directed self-checking bench for cla_serial_sub (WIDTH=8 and WIDTH=2 instances).
module tb_cla_serial_sub;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [7:0] a, b, diff;
    logic       borrow_out, overflow;

    logic       in_valid2, in_ready2, out_valid2, out_ready2;
    logic [1:0] a2, b2, diff2;
    logic       borrow2, overflow2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cla_serial_sub #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .borrow_out(borrow_out), .overflow(overflow)
    );

    cla_serial_sub #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid2), .in_ready(in_ready2), .a(a2), .b(b2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .diff(diff2), .borrow_out(borrow2), .overflow(overflow2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full transaction on the 8-bit instance with out_ready held high.
    task automatic op8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                       input logic [7:0] ed, input logic eb, input logic eo);
        int lat;
        lat = 0;
        for (int i = 0; i < 20 && !in_ready; i++) tick();
        check({tag, "_rdy"}, 32'(in_ready), 32'(1));
        in_valid = 1'b1; a = av; b = bv;
        tick();
        in_valid = 1'b0;
        check({tag, "_busy"}, 32'(in_ready), 32'(0));
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(4));
        check({tag, "_diff"}, 32'(diff), 32'(ed));
        check({tag, "_borrow"}, 32'(borrow_out), 32'(eb));
        check({tag, "_ovf"}, 32'(overflow), 32'(eo));
        tick();
        check({tag, "_vld_clr"}, 32'(out_valid), 32'(0));
        check({tag, "_idle"}, 32'(in_ready), 32'(1));
    endtask

    initial begin
        int lat;
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
        in_valid2 = 1'b0; out_ready2 = 1'b1; a2 = '0; b2 = '0;
        #12;
        check("rst_in_ready", 32'(in_ready), 32'(1));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_diff", 32'(diff), 32'(0));
        check("rst_borrow", 32'(borrow_out), 32'(0));
        check("rst_ovf", 32'(overflow), 32'(0));
        check("rst2_in_ready", 32'(in_ready2), 32'(1));
        check("rst2_out_valid", 32'(out_valid2), 32'(0));
        rst_n = 1'b1;
        tick();

        op8("t5a_3c", 8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0);
        op8("t00_01", 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
        op8("t80_01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        op8("t7f_ff", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
        op8("t33_33", 8'h33, 8'h33, 8'h00, 1'b0, 1'b0);
        op8("ta5_00", 8'hA5, 8'h00, 8'hA5, 1'b0, 1'b0);

        // Back-pressure: result held while out_ready=0, new operands wait.
        out_ready = 1'b0;
        in_valid = 1'b1; a = 8'hC8; b = 8'h10;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("bp_lat", 32'(lat), 32'(4));
        check("bp_diff", 32'(diff), 32'(8'hB8));
        in_valid = 1'b1; a = 8'h01; b = 8'h01;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_diff", 32'(diff), 32'(8'hB8));
            check("bp_hold_vld", 32'(out_valid), 32'(1));
            check("bp_hold_rdy", 32'(in_ready), 32'(0));
            check("bp_hold_flags", 32'({borrow_out, overflow}), 32'(0));
        end
        out_ready = 1'b1;
        tick();
        check("bp_rel_vld", 32'(out_valid), 32'(0));
        check("bp_rel_rdy", 32'(in_ready), 32'(1));
        check("bp_rel_diff", 32'(diff), 32'(8'hB8));
        tick();
        in_valid = 1'b0;
        check("bp_acc_rdy", 32'(in_ready), 32'(0));
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("bp2_lat", 32'(lat), 32'(4));
        check("bp2_diff", 32'(diff), 32'(8'h00));
        tick();

        // Reset in the middle of RUN discards the partial result.
        in_valid = 1'b1; a = 8'hF0; b = 8'h0F;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("mid_partial_diff", 32'(diff), 32'(8'h01));
        rst_n = 1'b0;
        #1;
        check("mr_in_ready", 32'(in_ready), 32'(1));
        check("mr_out_valid", 32'(out_valid), 32'(0));
        check("mr_diff", 32'(diff), 32'(0));
        check("mr_flags", 32'({borrow_out, overflow}), 32'(0));
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("mr_no_valid", 32'(out_valid), 32'(0));
        end
        op8("t10_01", 8'h10, 8'h01, 8'h0F, 1'b0, 1'b0);

        // WIDTH=2 instance: single RUN cycle.
        in_valid2 = 1'b1; a2 = 2'b00; b2 = 2'b11;
        tick();
        in_valid2 = 1'b0;
        lat = 0;
        while (!out_valid2 && lat < 20) begin
            tick();
            lat++;
        end
        check("w2_lat", 32'(lat), 32'(1));
        check("w2_diff", 32'(diff2), 32'(2'b01));
        check("w2_borrow", 32'(borrow2), 32'(1));
        check("w2_ovf", 32'(overflow2), 32'(0));
        tick();
        check("w2_idle", 32'(in_ready2), 32'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
